// File: rtl/fifo_drain_pkg.sv
// Shared types for the fifo drain block: FSM state encoding.
package fifo_drain_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_ERROR    = 2'd3
   } fifo_drain_state_e;

endpackage

// File: rtl/fifo_drain_if.sv
// Fifo pop side plus memory request/response handshake bundle.
// master = the drain engine, slave = fifo and memory side.
interface fifo_drain_if #(
   parameter int WIDTH = 8
) ();
   logic             fifo_not_empty;
   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_pop;
   logic             mem_req_valid;
   logic [WIDTH-1:0] mem_req_data;
   logic             mem_req_ready;
   logic             mem_rsp_valid;
   logic             mem_rsp_error;

   modport master (
      input  fifo_not_empty, fifo_rdata, mem_req_ready, mem_rsp_valid, mem_rsp_error,
      output fifo_pop, mem_req_valid, mem_req_data
   );

   modport slave (
      output fifo_not_empty, fifo_rdata, mem_req_ready, mem_rsp_valid, mem_rsp_error,
      input  fifo_pop, mem_req_valid, mem_req_data
   );
endinterface

// File: rtl/fifo_drain_timer.sv
// Response timeout counter: clear has priority over enable; expired flags
// the terminal count TIMEOUT-1 so the caller can act in that same cycle.
module drain_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int TW = $clog2(TIMEOUT);

   logic [TW-1:0] count_r;

   // Count register: cleared on request accept, advanced while waiting.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_r <= {TW{1'b0}};
      end else if (clr) begin
         count_r <= {TW{1'b0}};
      end else if (en) begin
         count_r <= count_r + TW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == TW'(TIMEOUT - 1));
endmodule

// File: rtl/fifo_drain.sv
// Pops entries from a first-word fall-through fifo and forwards each one as a
// memory request, retrying on error response or timeout up to MAX_RETRY times
// before parking in ERROR with a sticky flag.
module fifo_drain
   import fifo_drain_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int TIMEOUT   = 16,
   parameter int MAX_RETRY = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clock,
   input  logic             reset,
   fifo_drain_if.master     bus,
   input  logic             err_clr,
   output logic             busy,
   output logic             error,
   output logic [CNT_W-1:0] done_count
);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   fifo_drain_state_e state_r, state_nxt_s;
   logic [WIDTH-1:0]  hold_r, hold_nxt_s;
   logic [RW-1:0]     retry_r, retry_nxt_s;
   logic              error_r, error_nxt_s;
   logic [CNT_W-1:0]  done_r, done_nxt_s;
   logic              pop_s;
   logic              timer_clr_s;
   logic              timer_en_s;
   logic              expired_s;

   drain_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clr     (timer_clr_s),
      .en      (timer_en_s),
      .expired (expired_s)
   );

   // State and datapath registers; a reset drops any held (already popped) entry.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         hold_r  <= {WIDTH{1'b0}};
         retry_r <= {RW{1'b0}};
         error_r <= 1'b0;
         done_r  <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         hold_r  <= hold_nxt_s;
         retry_r <= retry_nxt_s;
         error_r <= error_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   // Next-state logic; a valid response is checked before the timeout so it wins a tie.
   always_comb begin
      state_nxt_s = state_r;
      hold_nxt_s  = hold_r;
      retry_nxt_s = retry_r;
      error_nxt_s = error_r;
      done_nxt_s  = done_r;
      pop_s       = 1'b0;
      timer_clr_s = 1'b0;
      timer_en_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // Gating with reset keeps pop quiet while reset is held.
            if (bus.fifo_not_empty && reset) begin
               pop_s       = 1'b1;
               hold_nxt_s  = bus.fifo_rdata;
               retry_nxt_s = {RW{1'b0}};
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (bus.mem_req_ready) begin
               timer_clr_s = 1'b1;
               state_nxt_s = ST_WAIT_RSP;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_WAIT_RSP: begin
            timer_en_s = 1'b1;
            if (bus.mem_rsp_valid && !bus.mem_rsp_error) begin
               done_nxt_s  = done_r + CNT_W'(1);
               state_nxt_s = ST_IDLE;
            end else if (bus.mem_rsp_valid || expired_s) begin
               if (retry_r < RW'(MAX_RETRY)) begin
                  retry_nxt_s = retry_r + RW'(1);
                  state_nxt_s = ST_ISSUE;
               end else begin
                  error_nxt_s = 1'b1;
                  state_nxt_s = ST_ERROR;
               end
            end else begin
               state_nxt_s = ST_WAIT_RSP;
            end
         end
         ST_ERROR: begin
            if (err_clr) begin
               error_nxt_s = 1'b0;
               hold_nxt_s  = {WIDTH{1'b0}};
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ERROR;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   assign bus.fifo_pop      = pop_s;
   assign bus.mem_req_valid = (state_r == ST_ISSUE);
   assign bus.mem_req_data  = (state_r == ST_ISSUE) ? hold_r : {WIDTH{1'b0}};
   assign busy              = (state_r != ST_IDLE);
   assign error             = error_r;
   assign done_count        = done_r;
endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: a per-cycle vector table for the basic flow
// and back-to-back entries, then hand-written retry/timeout/reset sequences.
module tb_fifo_drain;
   localparam int WIDTH     = 8;
   localparam int TIMEOUT   = 16;
   localparam int MAX_RETRY = 2;
   localparam int CNT_W     = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             err_clr = 1'b0;
   logic             busy;
   logic             error;
   logic [CNT_W-1:0] done_count;

   fifo_drain_if #(.WIDTH(WIDTH)) bus ();

   fifo_drain #(
      .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .err_clr    (err_clr),
      .busy       (busy),
      .error      (error),
      .done_count (done_count)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int exp_done = 0;

   typedef struct {
      logic       ne;
      logic [7:0] rd;
      logic       rdy;
      logic       rv;
      logic       pop;
      logic       val;
      logic [7:0] data;
      logic       bsy;
      logic [15:0] done;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic ne, input logic [7:0] rd, input logic rdy,
                               input logic rv, input logic pop, input logic val,
                               input logic [7:0] data, input logic bsy, input logic [15:0] done);
      vec_t v;
      v.ne = ne; v.rd = rd; v.rdy = rdy; v.rv = rv;
      v.pop = pop; v.val = val; v.data = data; v.bsy = bsy; v.done = done;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #2;
   endtask

   // {pop, req_valid, req_data, busy, error, done_count}
   function automatic logic [27:0] outs();
      return {bus.fifo_pop, bus.mem_req_valid, bus.mem_req_data, busy, error, done_count};
   endfunction

   task automatic idle_inputs();
      bus.fifo_not_empty = 1'b0;
      bus.fifo_rdata     = 8'h00;
      bus.mem_req_ready  = 1'b0;
      bus.mem_rsp_valid  = 1'b0;
      bus.mem_rsp_error  = 1'b0;
   endtask

   // Pops one entry, accepts every request, and answers each accepted request
   // 'delay' cycles into WAIT_RSP; the first n_err answers carry an error.
   task automatic run_entry(input string tag, input logic [7:0] d, input int n_err,
                            input int delay, output int issues);
      int k;
      int nresp;
      int pops;
      bit finished;
      k = -1; nresp = 0; pops = 0; finished = 1'b0; issues = 0;
      bus.fifo_not_empty = 1'b1;
      bus.fifo_rdata     = d;
      bus.mem_req_ready  = 1'b1;
      bus.mem_rsp_valid  = 1'b0;
      bus.mem_rsp_error  = 1'b0;
      #2;
      check({tag, "_pop"}, bus.fifo_pop, 1'b1);
      check({tag, "_err_low"}, error, 1'b0);
      next_cycle();
      bus.fifo_not_empty = 1'b0;
      bus.fifo_rdata     = 8'h00;
      for (int c = 0; c < 200 && !finished; c++) begin
         bus.mem_rsp_valid = (k == delay);
         bus.mem_rsp_error = (k == delay) && (nresp < n_err);
         #2;
         if (!busy) begin
            finished = 1'b1;
         end else begin
            if (bus.fifo_pop) pops++;
            if (bus.mem_req_valid) begin
               issues++;
               check({tag, "_req_data"}, bus.mem_req_data, d);
            end
            if (bus.mem_req_valid && bus.mem_req_ready) k = 1;
            else if (k == delay) begin nresp++; k = -1; end
            else if (k > 0) k++;
         end
         next_cycle();
      end
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_error = 1'b0;
      check({tag, "_complete"}, finished, 1'b1);
      check({tag, "_no_extra_pop"}, pops, 0);
   endtask

   initial begin
      int acc[$];
      int pops;
      int vals;
      int iss;
      idle_inputs();

      // Per-cycle table: entry A5, then 01/02/03 with a 4-cycle ready stall on 01.
      tbl[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0);
      tbl[1]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 16'd0);
      tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0);
      tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1);
      tbl[4]  = mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1);
      tbl[5]  = mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 16'd1);
      tbl[6]  = mk(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 16'd1);
      tbl[7]  = mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 16'd1);
      tbl[8]  = mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 16'd1);
      tbl[9]  = mk(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 16'd1);
      tbl[10] = mk(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd1);
      tbl[11] = mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd2);
      tbl[12] = mk(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 16'd2);
      tbl[13] = mk(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd2);
      tbl[14] = mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd3);
      tbl[15] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 16'd3);
      tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd3);
      tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd4);

      repeat (3) @(posedge clock);
      #2;
      reset = 1'b1;
      #2;
      check("reset_state", outs(), 28'h0);
      next_cycle();

      // Tests 1 and 2 from the table.
      for (int i = 0; i < 18; i++) begin
         bus.fifo_not_empty = tbl[i].ne;
         bus.fifo_rdata     = tbl[i].rd;
         bus.mem_req_ready  = tbl[i].rdy;
         bus.mem_rsp_valid  = tbl[i].rv;
         bus.mem_rsp_error  = 1'b0;
         #2;
         check($sformatf("vec%0d", i), outs(),
               {tbl[i].pop, tbl[i].val, tbl[i].data, tbl[i].bsy, 1'b0, tbl[i].done});
         next_cycle();
      end
      idle_inputs();
      exp_done = 4;

      // Test 3: no response ever -> 3 issues spaced by TIMEOUT wait cycles, then ERROR.
      bus.fifo_not_empty = 1'b1;
      bus.fifo_rdata     = 8'h5A;
      bus.mem_req_ready  = 1'b1;
      #2;
      check("t3_pop", bus.fifo_pop, 1'b1);
      next_cycle();
      bus.fifo_not_empty = 1'b0;
      pops = 0;
      for (int c = 0; c < 60; c++) begin
         #2;
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            acc.push_back(c);
            check("t3_req_data", bus.mem_req_data, 8'h5A);
         end
         if (bus.fifo_pop) pops++;
         next_cycle();
      end
      check("t3_issue_count", acc.size(), 3);
      if (acc.size() == 3) begin
         // accept cycle + TIMEOUT cycles in WAIT_RSP before the re-issue
         check("t3_gap1", acc[1] - acc[0], TIMEOUT + 1);
         check("t3_gap2", acc[2] - acc[1], TIMEOUT + 1);
      end
      check("t3_pops_during_retry", pops, 0);
      #2;
      check("t3_error_set", error, 1'b1);
      check("t3_busy_in_error", busy, 1'b1);
      next_cycle();
      bus.fifo_not_empty = 1'b1;
      bus.fifo_rdata     = 8'h99;
      pops = 0; vals = 0;
      for (int c = 0; c < 5; c++) begin
         #2;
         if (bus.fifo_pop) pops++;
         if (bus.mem_req_valid) vals++;
         next_cycle();
      end
      check("t3_no_pop_in_error", pops, 0);
      check("t3_no_req_in_error", vals, 0);
      err_clr = 1'b1;
      #2;
      check("t3_clr_cycle_no_pop", bus.fifo_pop, 1'b0);
      next_cycle();
      err_clr = 1'b0;
      run_entry("t3_after_clr", 8'hC3, 0, 1, iss);
      exp_done++;
      check("t3_after_issues", iss, 1);
      check("t3_done", done_count, exp_done);

      // Test 4: error response then good response -> two issues, one completion.
      run_entry("t4", 8'h77, 1, 1, iss);
      exp_done++;
      check("t4_issues", iss, 2);
      check("t4_done", done_count, exp_done);
      check("t4_error_low", error, 1'b0);

      // Test 5: good response in the cycle the timer hits TIMEOUT-1 -> no retry.
      run_entry("t5", 8'h3C, 0, TIMEOUT, iss);
      exp_done++;
      check("t5_issues", iss, 1);
      check("t5_done", done_count, exp_done);
      check("t5_error_low", error, 1'b0);

      // Test 6: reset during WAIT_RSP clears outputs at once; stays idle afterwards.
      bus.fifo_not_empty = 1'b1;
      bus.fifo_rdata     = 8'h11;
      bus.mem_req_ready  = 1'b1;
      next_cycle();
      next_cycle();
      #1;
      check("t6_in_wait_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      check("t6_reset_immediate", outs(), 28'h0);
      next_cycle();
      check("t6_reset_held", outs(), 28'h0);
      bus.fifo_not_empty = 1'b0;
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #2;
         check($sformatf("t6_idle%0d", c), outs(), 28'h0);
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Pop-side consumer for the generic fifo. Watches fifo `not_empty`/`rdata` (first-word fall-through), pops one entry and forwards it to a downstream memory/request port with a valid/ready request and a separate response handshake.
- Handles per-request response timeout and bounded retry. Raises a sticky error when retries are exhausted.
- Sits between request queues (e.g. writeback/store queues) and the main-memory interface.

Parameters:
WIDTH, 8, entry/request data width
TIMEOUT, 16, max cycles in WAIT_RSP before a timeout event (>=2)
MAX_RETRY, 2, re-issues allowed per entry after error/timeout (>=0)
CNT_W, 16, width of completed-entry counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
fifo_not_empty  in  1  fifo holds >=1 entry; fifo_rdata valid
fifo_rdata  in  WIDTH  head entry of fifo
fifo_pop  out  1  pop head entry (1-cycle pulse)
mem_req_valid  out  1  request valid
mem_req_data  out  WIDTH  request payload
mem_req_ready  in  1  downstream accepts request this cycle
mem_rsp_valid  in  1  response for outstanding request
mem_rsp_error  in  1  response carries error (qualified by mem_rsp_valid)
err_clr  in  1  clear ERROR state / sticky error
busy  out  1  state != IDLE
error  out  1  sticky: entry abandoned after retries
done_count  out  CNT_W  entries completed without abandonment

Behaviour:
- Reset (async, reset==0): state IDLE; fifo_pop=0, mem_req_valid=0, mem_req_data=0, busy=0, error=0, done_count=0, retry=0, timer=0.
- FSM states: IDLE, ISSUE, WAIT_RSP, ERROR.
- IDLE: if fifo_not_empty, fifo_pop=1 combinationally that cycle, fifo_rdata captured into hold reg, retry<=0, next ISSUE. fifo_pop never asserted outside IDLE or when fifo_not_empty=0.
- ISSUE: mem_req_valid=1, mem_req_data=hold. Valid/data stay stable until mem_req_ready; no retraction. On ready: next WAIT_RSP, timer<=0. mem_rsp_valid ignored in ISSUE.
- WAIT_RSP: timer increments each cycle.
  - mem_rsp_valid && !mem_rsp_error: done_count++ (wraps at 2^CNT_W), next IDLE.
  - mem_rsp_valid && mem_rsp_error, or no rsp with timer==TIMEOUT-1 (timeout): if retry<MAX_RETRY then retry++, next ISSUE (same hold data); else next ERROR, error<=1.
  - A valid response and the timeout in the same cycle: response wins.
- ERROR: mem_req_valid=0, no pops. err_clr=1 clears error, discards hold, next IDLE. err_clr outside ERROR is ignored.
- Latency: fifo_not_empty seen in IDLE at cycle N gives fifo_pop at N and mem_req_valid at N+1. Minimum per-entry period is 3 cycles (IDLE, ISSUE with ready=1, WAIT_RSP with immediate rsp). The IDLE bubble is required.
- busy=1 in ISSUE, WAIT_RSP, ERROR.
- Reset mid-operation: held entry is lost (already popped). Outputs return to reset values immediately; no spurious fifo_pop or mem_req_valid is permitted while reset==0.
- Timer width: $clog2(TIMEOUT). Retry width: $clog2(MAX_RETRY+1), minimum 1.

Decomposition:
- Shared package: fifo_drain_state_e enum (IDLE, ISSUE, WAIT_RSP, ERROR) and encoding width constant.
- One sub-module, drain_timer: counter with clear/enable and terminal-count output `expired` at TIMEOUT-1. Reused for the timeout.
- Registers use the codebase flop macros with asynchronous active-low reset.

Test Plan:
1. Reset then fifo_not_empty=1, rdata=8'hA5, ready=1, rsp valid 1 cycle after issue -> pop at c0, req_valid/data=A5 at c1, done_count=1 at c3, busy=0.
2. Three back-to-back entries 8'h01/02/03, ready held 0 for 4 cycles on the first -> req_data stable at 01 through stall; order preserved; exactly three single-cycle pops; done_count=3.
3. TIMEOUT=16, MAX_RETRY=2, no response ever -> three issues of the same data, each 16 cycles apart after accept; then ERROR, error=1, no further pops. err_clr -> IDLE, error=0, next entry popped.
4. First response error=1, second response ok -> exactly two issues; done_count=1, error stays 0.
5. Response arriving in the same cycle timer hits TIMEOUT-1 -> counted as success, no retry.
6. Assert reset low during WAIT_RSP -> mem_req_valid=0, busy=0, done_count=0 immediately. After release with fifo empty, outputs stay idle.
